branch_predictor: RTL and testbench

//  Dynamic branch predictor (direct-mapped BTB + per-entry 2-bit counters) for the 5-stage core.

---
 rtl/bp_pkg.sv | 27 ++
 rtl/sat_counter.sv | 23 ++
 rtl/branch_predictor.sv | 128 ++++++++++++
 tb/tb_branch_predictor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, constants and index/tag helpers for the branch predictor
package bp_pkg;

    // Direction-counter seeds for a 2-bit counter; wider counters scale these up.
    localparam logic [1:0] CNT_WEAK_NT = 2'b01;
    localparam logic [1:0] CNT_WEAK_T  = 2'b10;

    // The tag field is sized for the widest legal tag.
    // Bits above TAG_W are always written as zero.
    typedef struct packed {
        logic        valid;
        logic        is_jump;
        logic [29:0] tag;
        logic [29:0] target;
    } btb_entry_t;

    // Table index: word-address bits just above the byte offset.
    function automatic logic [31:0] bp_idx(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag: the tag_w bits directly above the index.
    function automatic logic [29:0] bp_tag(input logic [31:0] pc, input int idx_w, input int tag_w);
        return 30'((pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - next-state logic for an up/down saturating counter
module sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] cur,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] nxt
);

    // Step toward all-ones or zero, holding at either end.
    always_comb begin
        nxt = cur;
        if (en) begin
            if (up && cur != '1) begin
                nxt = cur + W'(1);
            end else if (!up && cur != '0) begin
                nxt = cur - W'(1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit direction counters and mispredict stats
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    input  logic [31:0]       upd_pred_target,
    input  logic              flush_all,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Scale the 2-bit seeds so that the MSB still carries the taken/not-taken split.
    localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(CNT_WEAK_T) << (CNT_W - 2);
    localparam logic [CNT_W-1:0] WEAK_NT = (CNT_W'(CNT_WEAK_NT) << (CNT_W - 2))
                                         | ((CNT_W'(1) << (CNT_W - 2)) - CNT_W'(1));

    btb_entry_t       table_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q   [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [29:0]      up_tag;
    logic             lk_hit;
    logic             up_hit;
    logic [CNT_W-1:0] dir_nxt;
    logic [STAT_W-1:0] br_nxt;
    logic [STAT_W-1:0] mp_nxt;

    // Fetch-side lookup reads the registered table only, so a same-cycle update is not bypassed.
    always_comb begin
        lk_idx      = IDX_W'(bp_idx(if_pc, IDX_W));
        lk_hit      = table_q[lk_idx].valid && (table_q[lk_idx].tag == bp_tag(if_pc, IDX_W, TAG_W));
        pred_taken  = lk_hit && (table_q[lk_idx].is_jump || cnt_q[lk_idx][CNT_W-1]);
        pred_target = pred_taken ? {table_q[lk_idx].target, 2'b00} : if_pc + 32'd4;
    end

    // Resolve-side check of the prediction that travelled with the instruction.
    always_comb begin
        up_idx      = IDX_W'(bp_idx(upd_pc, IDX_W));
        up_tag      = bp_tag(upd_pc, IDX_W, TAG_W);
        up_hit      = table_q[up_idx].valid && (table_q[up_idx].tag == up_tag);
        mispredict  = rst && upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
    end

    // Jumps never train the counter; their direction is implied by is_jump.
    sat_counter #(.W(CNT_W)) u_dir_cnt (
        .cur (cnt_q[up_idx]),
        .en  (up_hit && !upd_is_jump),
        .up  (upd_taken),
        .nxt (dir_nxt)
    );

    sat_counter #(.W(STAT_W)) u_br_cnt (
        .cur (stat_branches),
        .en  (upd_valid),
        .up  (1'b1),
        .nxt (br_nxt)
    );

    sat_counter #(.W(STAT_W)) u_mp_cnt (
        .cur (stat_mispredicts),
        .en  (mispredict),
        .up  (1'b1),
        .nxt (mp_nxt)
    );

    // Table maintenance: flush wins over any update arriving in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
                cnt_q[i]   <= WEAK_NT;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                cnt_q[up_idx] <= dir_nxt;
                if (upd_taken) begin
                    table_q[up_idx].target  <= upd_target[31:2];
                    table_q[up_idx].is_jump <= upd_is_jump;
                end
            end else if (upd_taken) begin
                table_q[up_idx].valid   <= 1'b1;
                table_q[up_idx].tag     <= up_tag;
                table_q[up_idx].target  <= upd_target[31:2];
                table_q[up_idx].is_jump <= upd_is_jump;
                cnt_q[up_idx]           <= WEAK_T;
            end
        end
    end

    // Statistics survive flush_all and are cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            stat_branches    <= br_nxt;
            stat_mispredicts <= mp_nxt;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        flush_all;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [3:0]  stat_branches;
    logic [3:0]  stat_mispredicts;

    int n_checks;
    int n_pass;

    branch_predictor #(.ENTRIES(16), .TAG_W(8), .CNT_W(2), .STAT_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_is_jump      (upd_is_jump),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .flush_all        (flush_all),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one record per table slot, direction strength kept as 0..3.
    bit          m_valid  [16];
    bit          m_jump   [16];
    int          m_cnt    [16];
    int unsigned m_tag    [16];
    logic [31:0] m_target [16];
    int          m_br;
    int          m_mp;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        return (pc / 64) % 256;
    endfunction

    function automatic bit m_pt(input logic [31:0] pc);
        int i;
        i = m_idx(pc);
        return m_valid[i] && m_tag[i] == m_tagof(pc) && (m_jump[i] || m_cnt[i] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_pt(pc) ? m_target[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_misp();
        return rst && upd_valid && ((upd_pred_taken != upd_taken) ||
                                    (upd_taken && upd_pred_target != upd_target));
    endfunction

    function automatic logic [31:0] m_redirect();
        return upd_taken ? upd_target : upd_pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_jump[i] = 0; m_cnt[i] = 1; m_tag[i] = 0; m_target[i] = 0;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    // Advance one clock, applying the architectural update rules to the model.
    task automatic tick();
        bit mp;
        int i;
        bit hit;
        mp = m_misp();
        @(posedge clk);
        if (rst) begin
            if (upd_valid && m_br < 15) m_br++;
            if (mp && m_mp < 15) m_mp++;
            if (flush_all) begin
                for (int k = 0; k < 16; k++) m_valid[k] = 0;
            end else if (upd_valid) begin
                i   = m_idx(upd_pc);
                hit = m_valid[i] && m_tag[i] == m_tagof(upd_pc);
                if (hit) begin
                    if (!upd_is_jump) m_cnt[i] = upd_taken ? ((m_cnt[i] == 3) ? 3 : m_cnt[i] + 1)
                                                           : ((m_cnt[i] == 0) ? 0 : m_cnt[i] - 1);
                    if (upd_taken) begin
                        m_target[i] = upd_target;
                        m_jump[i]   = upd_is_jump;
                    end
                end else if (upd_taken) begin
                    m_valid[i] = 1; m_tag[i] = m_tagof(upd_pc); m_target[i] = upd_target;
                    m_jump[i] = upd_is_jump; m_cnt[i] = 2;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        upd_valid = 0; flush_all = 0; upd_is_jump = 0; upd_taken = 0;
        upd_pred_taken = 0; upd_pred_target = 0; upd_pc = 0; upd_target = 0;
    endtask

    // Drive an update whose carried prediction is whatever the model would have predicted.
    task automatic drive_upd(input logic [31:0] pc, input bit jump, input bit taken, input logic [31:0] tgt);
        upd_valid = 1; upd_pc = pc; upd_is_jump = jump; upd_taken = taken; upd_target = tgt;
        upd_pred_taken = m_pt(pc); upd_pred_target = m_ptgt(pc);
    endtask

    task automatic test_reset();
        rst = 0; idle(); upd_valid = 1; upd_pred_taken = 1; if_pc = 32'hFFFF_FFFC;
        m_reset();
        #1;
        n_checks++; if (pred_taken !== 1'b0) $display("FAIL reset_pred_taken got=%0b exp=0", pred_taken); else n_pass++;
        n_checks++; if (pred_target !== 32'h0) $display("FAIL reset_pred_target_wrap got=%h exp=0", pred_target); else n_pass++;
        n_checks++; if (mispredict !== 1'b0) $display("FAIL reset_mispredict got=%0b exp=0", mispredict); else n_pass++;
        n_checks++; if (stat_branches !== 4'h0 || stat_mispredicts !== 4'h0)
            $display("FAIL reset_stats got=%h/%h exp=0/0", stat_branches, stat_mispredicts); else n_pass++;
        @(posedge clk); #1;
        rst = 1; idle();
    endtask

    task automatic test_cold_taken();
        if_pc = 32'h100;
        drive_upd(32'h100, 0, 1, 32'h80);
        #1;
        n_checks++; if (pred_taken !== 1'b0) $display("FAIL cold_same_cycle_pred got=%0b exp=0", pred_taken); else n_pass++;
        n_checks++; if (mispredict !== 1'b1) $display("FAIL cold_mispredict got=%0b exp=1", mispredict); else n_pass++;
        n_checks++; if (redirect_pc !== 32'h80) $display("FAIL cold_redirect got=%h exp=80", redirect_pc); else n_pass++;
        tick(); idle(); #1;
        n_checks++; if (pred_taken !== 1'b1) $display("FAIL cold_pred_taken got=%0b exp=1", pred_taken); else n_pass++;
        n_checks++; if (pred_target !== 32'h80) $display("FAIL cold_pred_target got=%h exp=80", pred_target); else n_pass++;
    endtask

    task automatic test_hysteresis();
        bit outcome [10] = '{1, 0, 1, 1, 1, 0, 0, 0, 0, 1};
        bit expect_p [10] = '{1, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        if_pc = 32'h204;
        for (int s = 0; s < 10; s++) begin
            drive_upd(32'h204, 0, outcome[s], 32'h380);
            tick(); idle(); #1;
            n_checks++; if (pred_taken !== expect_p[s])
                $display("FAIL hyst_step%0d got=%0b exp=%0b", s, pred_taken, expect_p[s]); else n_pass++;
        end
    endtask

    task automatic test_alias();
        if_pc = 32'h140; #1;
        n_checks++; if (pred_taken !== 1'b0) $display("FAIL alias_miss got=%0b exp=0", pred_taken); else n_pass++;
        drive_upd(32'h140, 0, 1, 32'h500);
        tick(); idle(); #1;
        n_checks++; if (pred_target !== 32'h500) $display("FAIL alias_new_target got=%h exp=500", pred_target); else n_pass++;
        if_pc = 32'h100; #1;
        n_checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h104)
            $display("FAIL alias_evicted got=%0b/%h exp=0/104", pred_taken, pred_target); else n_pass++;
    endtask

    task automatic test_jump();
        if_pc = 32'h20;
        drive_upd(32'h20, 1, 1, 32'h400);
        tick(); idle(); #1;
        n_checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h400)
            $display("FAIL jump_pred got=%0b/%h exp=1/400", pred_taken, pred_target); else n_pass++;
        for (int s = 0; s < 2; s++) begin
            drive_upd(32'h20, 0, 0, 32'h0);
            upd_pred_taken = 1; upd_pred_target = 32'h400;
            #1;
            n_checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h24)
                $display("FAIL jump_nt_misp%0d got=%0b/%h exp=1/24", s, mispredict, redirect_pc); else n_pass++;
            tick(); idle(); #1;
            n_checks++; if (pred_taken !== 1'b1)
                $display("FAIL jump_ignores_cnt%0d got=%0b exp=1", s, pred_taken); else n_pass++;
        end
    endtask

    task automatic test_flush();
        int br_before;
        br_before = m_br;
        drive_upd(32'h300, 0, 1, 32'h600);
        flush_all = 1;
        tick(); idle();
        n_checks++; if (stat_branches !== 4'(br_before < 15 ? br_before + 1 : 15))
            $display("FAIL flush_stat_branches got=%0d exp=%0d", stat_branches, br_before + 1); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] pcs [4] = '{32'h20, 32'h140, 32'h204, 32'h300};
            if_pc = pcs[k]; #1;
            n_checks++; if (pred_taken !== 1'b0)
                $display("FAIL flush_miss pc=%h got=%0b exp=0", pcs[k], pred_taken); else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            if_pc = ($urandom_range(1, 2) << 6) | ($urandom_range(0, 15) << 2);
            idle();
            if ($urandom_range(0, 3) != 0) begin
                bit j;
                j = ($urandom_range(0, 7) == 0);
                drive_upd(($urandom_range(1, 2) << 6) | ($urandom_range(0, 15) << 2), j,
                          j ? 1'b1 : 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
                if ($urandom_range(0, 7) == 0) upd_pred_taken = ~upd_pred_taken;
            end
            flush_all = ($urandom_range(0, 31) == 0);
            #1;
            n_checks++; if (pred_taken !== m_pt(if_pc) || pred_target !== m_ptgt(if_pc))
                $display("FAIL rand_pred c=%0d pc=%h got=%0b/%h exp=%0b/%h", c, if_pc,
                         pred_taken, pred_target, m_pt(if_pc), m_ptgt(if_pc)); else n_pass++;
            n_checks++; if (mispredict !== m_misp() || (upd_valid && redirect_pc !== m_redirect()))
                $display("FAIL rand_misp c=%0d got=%0b/%h exp=%0b/%h", c, mispredict, redirect_pc,
                         m_misp(), m_redirect()); else n_pass++;
            tick();
            n_checks++; if (stat_branches !== 4'(m_br) || stat_mispredicts !== 4'(m_mp))
                $display("FAIL rand_stats c=%0d got=%0d/%0d exp=%0d/%0d", c, stat_branches,
                         stat_mispredicts, m_br, m_mp); else n_pass++;
        end
        idle();
    endtask

    task automatic test_stat_saturation();
        for (int s = 0; s < 20; s++) begin
            idle();
            upd_valid = 1; upd_pc = 32'h3C0 + 32'(s * 4); upd_taken = 0; upd_pred_taken = 1;
            tick();
        end
        idle();
        n_checks++; if (stat_branches !== 4'hF || stat_mispredicts !== 4'hF)
            $display("FAIL stat_saturate got=%h/%h exp=F/F", stat_branches, stat_mispredicts); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        idle();
        drive_upd(32'h84, 0, 1, 32'h700);
        tick(); idle();
        if_pc = 32'h84; #2;
        rst = 0; #1;
        m_reset();
        n_checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h88)
            $display("FAIL midrun_reset_pred got=%0b/%h exp=0/88", pred_taken, pred_target); else n_pass++;
        n_checks++; if (stat_branches !== 4'h0 || stat_mispredicts !== 4'h0)
            $display("FAIL midrun_reset_stats got=%h/%h exp=0/0", stat_branches, stat_mispredicts); else n_pass++;
        @(posedge clk); #1;
        rst = 1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_cold_taken();
        test_hysteresis();
        test_alias();
        test_jump();
        test_flush();
        test_random();
        test_stat_saturation();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
